// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//
// Multi-channel seven-segment scan controller. Producers post NUM_DIGITS hex
// nibbles (plus per-digit decimal-point requests) on their channel with a
// one-cycle valid pulse. Channel 0 is the background source; any higher
// channel that posted within the last HOLD_FRAMES scan frames overrides all
// lower ones. The displayed channel only changes on a frame boundary, so a
// single scan frame never mixes digits from two sources.
//
// Parameters:
//   NUM_DIGITS   digits scanned, one anode each
//   NUM_CH       producer channels (>= 2), channel 0 = background
//   DIV          clock cycles per digit slot
//   HOLD_FRAMES  frames an override channel stays up after its last post
//
// Ports:
//   clock      system clock
//   rst_n      asynchronous active-low reset
//   ch_valid   per-channel capture pulse
//   ch_data    packed nibbles, channel i at [i*NUM_DIGITS*4 +: NUM_DIGITS*4]
//   ch_dp      packed dp requests, channel i at [i*NUM_DIGITS +: NUM_DIGITS]
//   lz_en      leading-zero blanking enable
//   bright     4-bit brightness (only with SEG_BRIGHT_PWM_EN defined)
//   an         active-low anodes, one-hot-low
//   seg        active-low segments {g,f,e,d,c,b,a}
//   dp         active-low decimal point
//   active_ch  channel shown in the current frame
//
// Build option:
//   SEG_BRIGHT_PWM_EN  adds the bright input; anodes are only driven for the
//                      first ((bright+1)*DIV)>>4 cycles of every digit slot.
//                      Undefined: anodes stay on for the whole slot.
// ---------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int NUM_CH      = 3,
  parameter int DIV         = 50_000,
  parameter int HOLD_FRAMES = 100
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH*NUM_DIGITS*4-1:0] ch_data,
  input  logic [NUM_CH*NUM_DIGITS-1:0]   ch_dp,
  input  logic                           lz_en,
`ifdef SEG_BRIGHT_PWM_EN
  input  logic [3:0]                     bright,
`endif
  output logic [NUM_DIGITS-1:0]          an,
  output logic [6:0]                     seg,
  output logic                           dp,
  output logic [$clog2(NUM_CH)-1:0]      active_ch
);

  localparam int DW = NUM_DIGITS * 4;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int CW = $clog2(NUM_CH);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_FRAMES);

  // Hex digit to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Scan timing: prescaler and digit index
  // -------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic [IW-1:0] digit_idx;
  logic          tick;
  logic          frame_end;

  assign tick      = (presc == PRESC_LAST);
  assign frame_end = tick && (digit_idx == DIGIT_LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      digit_idx <= '0;
    end else begin
      if (tick) begin
        presc <= '0;
        if (digit_idx == DIGIT_LAST) digit_idx <= '0;
        else                         digit_idx <= digit_idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel shadow registers
  // -------------------------------------------------------------------------
  logic [DW-1:0]         shadow_data [NUM_CH];
  logic [NUM_DIGITS-1:0] shadow_dp   [NUM_CH];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_data[i] <= '0;
        shadow_dp[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          shadow_data[i] <= ch_data[i*DW +: DW];
          shadow_dp[i]   <= ch_dp[i*NUM_DIGITS +: NUM_DIGITS];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Override hold counters (channel 0 never times out, so it has none).
  // A fresh post reloads the counter even on a frame boundary, so a producer
  // that keeps posting never drops off the display.
  // -------------------------------------------------------------------------
  logic [HW-1:0] hold [1:NUM_CH-1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_CH; i++) hold[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_CH; i++) begin
        if (ch_valid[i])                        hold[i] <= HOLD_LOAD;
        else if (frame_end && (hold[i] != '0))  hold[i] <= hold[i] - HW'(1);
      end
    end
  end

  // Highest channel still holding wins; falls back to the background.
  logic [CW-1:0] sel;

  always_comb begin
    sel = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (hold[i] != '0) sel = CW'(i);
    end
  end

  // -------------------------------------------------------------------------
  // Frame snapshot: the only thing the output stage reads, so a capture in
  // the middle of a frame cannot tear the digits already being scanned.
  // -------------------------------------------------------------------------
  logic [DW-1:0]         snap_data;
  logic [NUM_DIGITS-1:0] snap_dp;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      active_ch <= '0;
      snap_data <= '0;
      snap_dp   <= '0;
    end else if (frame_end) begin
      active_ch <= sel;
      snap_data <= shadow_data[sel];
      snap_dp   <= shadow_dp[sel];
    end
  end

  // -------------------------------------------------------------------------
  // Leading-zero detection: upper_zero[k] is set when digits k..MSD are all
  // zero, built by walking down from the most significant digit.
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_blank;

  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run && (snap_data[k*4 +: 4] == 4'h0);
      upper_zero[k] = zero_run;
    end
  end

  assign cur_nib   = snap_data[{digit_idx, 2'b00} +: 4];
  assign cur_blank = lz_en && (digit_idx != '0) && upper_zero[digit_idx];

  // -------------------------------------------------------------------------
  // Anode duty control
  // -------------------------------------------------------------------------
  logic anode_on;

`ifdef SEG_BRIGHT_PWM_EN
  logic [3:0]  bright_q;
  logic [31:0] on_limit;

  // Brightness only changes at slot boundaries so a slot is never cut short.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)    bright_q <= '0;
    else if (tick) bright_q <= bright;
  end

  assign on_limit = ((32'(bright_q) + 32'd1) * 32'(DIV)) >> 4;
  assign anode_on = (32'(presc) < on_limit);
`else
  assign anode_on = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Registered outputs: one clock behind the digit index.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= anode_on ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
      seg <= cur_blank ? 7'h7F : hex_to_seg(cur_nib);
      dp  <= ~snap_dp[digit_idx];
    end
  end

endmodule
